// File: rtl/tape_writer_pkg.sv
// tm_pkg: shared definitions for the Turing-machine tape block.
//   - symbol bus constants (3-bit one-hot-or-zero) and 2-bit storage codes
//   - sym_enc / sym_dec conversions and the sym_valid check
//   - tape sequencer FSM state enum and the step request struct
package tm_pkg;

    localparam int SYM_W  = 3;
    localparam int CODE_W = 2;

    // Symbol bus values {s2,s1,s0}
    localparam logic [SYM_W-1:0] SYM_BLANK = 3'b000;
    localparam logic [SYM_W-1:0] SYM_S0    = 3'b001;
    localparam logic [SYM_W-1:0] SYM_S1    = 3'b010;
    localparam logic [SYM_W-1:0] SYM_S2    = 3'b100;

    // Cell storage codes
    localparam logic [CODE_W-1:0] C_BLANK = 2'b00;
    localparam logic [CODE_W-1:0] C_S0    = 2'b01;
    localparam logic [CODE_W-1:0] C_S1    = 2'b10;
    localparam logic [CODE_W-1:0] C_S2    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_READY  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } tw_state_e;

    // One action from the controller
    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic             dir;   // 1 = right, 0 = left
        logic             halt;
    } step_req_t;

    // At most one bit set; clearing the lowest set bit must leave zero.
    function automatic logic sym_valid(input logic [SYM_W-1:0] s);
        return (s & (s - 3'd1)) == 3'd0;
    endfunction

    // Only called on valid symbols; invalid ones fall through to blank.
    function automatic logic [CODE_W-1:0] sym_enc(input logic [SYM_W-1:0] s);
        case (s)
            SYM_S0:  return C_S0;
            SYM_S1:  return C_S1;
            SYM_S2:  return C_S2;
            default: return C_BLANK;
        endcase
    endfunction

    function automatic logic [SYM_W-1:0] sym_dec(input logic [CODE_W-1:0] c);
        case (c)
            C_S0:    return SYM_S0;
            C_S1:    return SYM_S1;
            C_S2:    return SYM_S2;
            default: return SYM_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/tape_writer_if.sv
// tape_writer_if: control/step bus between the machine controller and the
// tape block.
//   preload : ld_en, ld_addr, ld_sym
//   control : start, clear
//   step    : step_valid / step_ready handshake with wr_sym, wr_dir, wr_halt
//   status  : rd_sym (symbol under head), head_pos, done, err
// master = controller side, slave = tape_writer.
interface tape_writer_if
    import tm_pkg::*;
#(
    parameter int TAPE_LEN = 16
);
    localparam int AW = $clog2(TAPE_LEN);

    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [SYM_W-1:0] ld_sym;
    logic             start;
    logic             clear;
    logic             step_valid;
    logic             step_ready;
    logic [SYM_W-1:0] wr_sym;
    logic             wr_dir;
    logic             wr_halt;
    logic [SYM_W-1:0] rd_sym;
    logic [AW-1:0]    head_pos;
    logic             done;
    logic             err;

    modport master (
        output ld_en, ld_addr, ld_sym, start, clear,
        output step_valid, wr_sym, wr_dir, wr_halt,
        input  step_ready, rd_sym, head_pos, done, err
    );

    modport slave (
        input  ld_en, ld_addr, ld_sym, start, clear,
        input  step_valid, wr_sym, wr_dir, wr_halt,
        output step_ready, rd_sym, head_pos, done, err
    );

endinterface

// File: rtl/tape_writer_tape_ram.sv
// tape_ram: DEPTH x 2-bit cell storage for the tape.
//   clk, rst_n : clock, async active-low clear of every cell to blank
//   we, waddr, wdata : single synchronous write port
//   raddr, rdata     : combinational read port
// Callers keep waddr inside 0..DEPTH-1.
module tape_ram
    import tm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [DEPTH-1:0][CODE_W-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tape_writer.sv
// tape_writer: tape storage and head sequencer for the universal Turing
// machine. Presents the symbol under the head on rd_sym and applies one
// write/move action per accepted step.
//   clk, rst_n : clock, async active-low reset (tape cleared to blank)
//   bus        : tape_writer_if slave (preload, start/clear, step handshake,
//                rd_sym / head_pos / done / err status)
// FSM: IDLE -> FETCH -> READY -> {FETCH, HALTED, FAULT}; clear -> IDLE.
module tape_writer
    import tm_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    localparam int AW = $clog2(TAPE_LEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    tape_writer_if.slave bus
);

    tw_state_e state, state_nxt;

    logic [AW-1:0]     head;
    logic [SYM_W-1:0]  rd_sym_q;
    step_req_t         req;

    logic              accept;
    logic              sym_ok;
    logic              at_edge;
    logic              move;
    logic              ld_ok;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [CODE_W-1:0] ram_wdata;
    logic [CODE_W-1:0] ram_rdata;

    logic              step_ready;
    logic              done;
    logic              err;

    assign req = '{sym: bus.wr_sym, dir: bus.wr_dir, halt: bus.wr_halt};

    // Step qualification; clear outranks a simultaneous step.
    assign accept  = (state == ST_READY) && bus.step_valid && !bus.clear;
    assign sym_ok  = sym_valid(req.sym);
    assign at_edge = req.dir ? (head == AW'(TAPE_LEN - 1)) : (head == '0);
    assign move    = accept && sym_ok && !req.halt && !at_edge;

    // ld_addr may exceed the tape when TAPE_LEN is not a power of two.
    assign ld_ok = (state == ST_IDLE) && bus.ld_en && !bus.clear &&
                   sym_valid(bus.ld_sym) && (int'(bus.ld_addr) < TAPE_LEN);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                // A preload in the same cycle wins over start.
                ST_IDLE:  if (bus.start && !bus.ld_en) state_nxt = ST_FETCH;
                ST_FETCH: state_nxt = ST_READY;
                ST_READY: begin
                    if (bus.step_valid) begin
                        if (!sym_ok)       state_nxt = ST_FAULT;
                        else if (req.halt) state_nxt = ST_HALTED;
                        else if (at_edge)  state_nxt = ST_FAULT;
                        else               state_nxt = ST_FETCH;
                    end
                end
                ST_HALTED: state_nxt = ST_HALTED;
                ST_FAULT:  state_nxt = ST_FAULT;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- outputs / write port ----------------
    always_comb begin
        step_ready = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = head;
        ram_wdata  = C_BLANK;
        case (state)
            ST_IDLE: begin
                if (ld_ok) begin
                    ram_we    = 1'b1;
                    ram_waddr = bus.ld_addr;
                    ram_wdata = sym_enc(bus.ld_sym);
                end
            end
            ST_READY: begin
                step_ready = 1'b1;
                // Halt and edge-fault steps still write the cell; only an
                // invalid symbol suppresses the write.
                if (accept && sym_ok) begin
                    ram_we    = 1'b1;
                    ram_waddr = head;
                    ram_wdata = sym_enc(req.sym);
                end
            end
            ST_HALTED: done = 1'b1;
            ST_FAULT:  err  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- head counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
        end else if (bus.clear) begin
            head <= '0;
        end else if (move) begin
            head <= req.dir ? head + 1'b1 : head - 1'b1;
        end
    end

    // ---------------- symbol under head ----------------
    // Loaded only at the end of FETCH so it holds steady across READY and
    // can be sampled on the same edge that accepts the step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sym_q <= SYM_BLANK;
        end else if (state == ST_FETCH && !bus.clear) begin
            rd_sym_q <= sym_dec(ram_rdata);
        end
    end

    tape_ram #(
        .DEPTH (TAPE_LEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (head),
        .rdata (ram_rdata)
    );

    assign bus.step_ready = step_ready;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.rd_sym     = rd_sym_q;
    assign bus.head_pos   = head;

endmodule

// File: doc/tape_writer.md
# tape_writer

Tape storage and head sequencer for the universal Turing machine; the writing side of the symbol interface that the next-state logic reads. Holds a TAPE_LEN-cell tape of 4-valued symbols. Presents the symbol under the head as the one-hot-or-zero `rd_sym` bus, which drives the next-state logic's `s2`, `s1` and `s0` inputs. On each accepted step it writes the action symbol, moves the head and fetches the new cell, with halt, edge-fault and preload handling.

## Interface
- `TAPE_LEN`, default 16: number of tape cells; must be ≥ 2.
- `AW`, default `$clog2(TAPE_LEN)`: head/address width (derived, not overridden).
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  reset: asynchronous assert, active-low.
- `ld_en`  in  1  preload strobe; honoured only in IDLE.
- `ld_addr`  in  AW  preload cell index.
- `ld_sym`  in  3  preload symbol, one-hot-or-zero.
- `start`  in  1  one-cycle pulse: leaves IDLE and begins fetching.
- `clear`  in  1  synchronous return to IDLE from any state; sets head to 0; tape contents are kept.
- `step_valid`  in  1  action from the controller is valid.
- `step_ready`  out  1  block can accept a step; `rd_sym` is valid while high.
- `wr_sym`  in  3  symbol to write, one-hot-or-zero.
- `wr_dir`  in  1  move direction: 1 = right (+1), 0 = left (−1).
- `wr_halt`  in  1  write, then halt without moving.
- `rd_sym`  out  3  registered symbol under the head: `{s2,s1,s0}`, with 000 = blank.
- `head_pos`  out  AW  current head index.
- `done`  out  1  high in HALTED.
- `err`  out  1  high in FAULT.

## Operation
- Cell storage is a 2-bit code: 00 = blank (000), 01 = s0 (001), 10 = s1 (010), 11 = s2 (100).
- A 3-bit bus with more than one bit set is invalid.
- FSM states:
  - IDLE → FETCH on `start`.
  - FETCH → READY always.
  - READY → FETCH, HALTED or FAULT on an accepted step.
  - HALTED and FAULT are sticky.
  - `clear` forces IDLE from every state and has top priority.
- IDLE:
  - `ld_en` writes `ld_sym` to `ld_addr`.
  - If `ld_en` and `start` arrive in the same cycle, the load is performed and `start` is ignored.
  - An invalid `ld_sym` is dropped silently.
  - An `ld_addr` ≥ TAPE_LEN is dropped.
- FETCH: `rd_sym` ← decode(cell[head]).
- READY: `step_ready` = 1. When `step_valid` is also high, the step is accepted:
  - If `wr_sym` is invalid: no write, no move, go to FAULT.
  - Else if `wr_halt`: cell[head] ← `wr_sym`, head unchanged, go to HALTED.
  - Else if the move leaves the tape (head = 0 with `wr_dir` = 0, or head = TAPE_LEN−1 with `wr_dir` = 1): the write happens, head is unchanged, go to FAULT. The head never wraps.
  - Else: write, head ± 1, go to FETCH.
- `ld_en`, `start`, `step_valid` and the action inputs are ignored in states where they are not listed.
- Reset values:
  - State IDLE.
  - All cells blank.
  - `head_pos` = 0, `rd_sym` = 000.
  - `step_ready`, `done` and `err` all 0.
- Reset mid-step discards the step. The tape is cleared to blank.

## Timing
- `start` sampled at edge t: FETCH during cycle t+1, `step_ready` = 1 and `rd_sym` valid from cycle t+2.
- Step accepted at edge t: write and head update take effect at edge t. FETCH in cycle t+1, `step_ready` high again in cycle t+2 with the new `rd_sym`.
- Throughput: one step per 2 cycles.
- `rd_sym` changes only on the FETCH edge. It is stable for the whole READY interval, so the external machine-state register may sample it at the same acceptance edge.
- `done` / `err` rise in the cycle after the accepting edge and fall the cycle after `clear`.
- `head_pos` is registered and updates at the accepting edge.

## Structure
- Package `tm_pkg` holds:
  - the symbol code constants;
  - the `sym_enc` (3-bit to 2-bit) and `sym_dec` (2-bit to 3-bit) functions;
  - a `sym_valid` check;
  - the FSM state enum.
- Sub-module `tape_ram`:
  - TAPE_LEN × 2-bit flops;
  - combinational read at an address;
  - one synchronous write port;
  - asynchronous clear to blank on `rst_n`.
- `tape_writer` contains the FSM, head counter, edge check and `rd_sym` register.

## Test plan
- Reset, then preload cell 0 = 010 and cell 1 = 100, then `start` → `step_ready` rises 2 cycles after `start` with `rd_sym` = 010 and `head_pos` = 0.
- Step `wr_sym` = 001, `wr_dir` = 1 → cell 0 reads back 001, `head_pos` = 1, `step_ready` is low 1 cycle, then `rd_sym` = 100.
- At head = 0, step with `wr_dir` = 0 and `wr_sym` = 100 → cell 0 = 100, `head_pos` stays 0, `err` = 1, `step_ready` stays 0. Then `clear` → IDLE with `err` = 0.
- At head = 15 (TAPE_LEN = 16), step right → FAULT; no wrap to 0.
- Step with `wr_halt` = 1 and `wr_sym` = 000 → cell blanked, `done` = 1, later `step_valid` pulses are ignored. Step with `wr_sym` = 011 → FAULT with the cell unchanged.
- `rst_n` low while in READY after 3 steps → all cells blank, `head_pos` = 0, outputs return to reset values. `ld_en` and `start` in the same IDLE cycle → load only, state stays IDLE.
